tiro_uc: RTL and testbench
==========================

Name: tiro_uc

Overview:
- Control unit (FSM) for the shot datapath `tiro`. It sits directly upstream of it and drives every control input of that datapath.
- Fires on player request and loads the ship position into the shot register.
- On each game tick it steps the shot one cell along `opcode`, then sweeps the asteroid memory for a collision. A hit destroys the asteroid; a hit, border or range limit unloads the shot.

Parameters:
- MAX_PASSOS, 15, number of completed sweeps without a hit before the shot expires (1..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- disparar  in  1  fire request, level; sampled only in IDLE.
- tick  in  1  one-cycle movement pulse from the game timer.
- colisao  in  1  datapath: shot position equals asteroid at current address.
- rco_contador  in  1  datapath: asteroid address counter at last entry.
- opcode  in  2  datapath: shot direction. 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
- x_borda_min, x_borda_max, y_borda_min, y_borda_max  in  1 each  datapath: shot at grid edge.
- conta_contador  out  1  increment the asteroid address counter.
- reset_cont  out  1  clear the asteroid address counter.
- select_mux_pos  out  2  shot register source. 00 ship position, 01 adder/subtractor result.
- select_mux_coor  out  1  coordinate being stepped. 1 = x, 0 = y.
- select_soma_sub  out  1  0 = add, 1 = subtract.
- enable_reg_nave  out  1  load the shot position register.
- reset_reg_nave  out  1  clear the shot position register.
- enable_mem_aste  out  1  write the asteroid memory at the current address.
- enable_mem_load  out  1  write the shot-loaded flag.
- new_load  out  1  data for the shot-loaded flag.
- new_destruido  out  1  data for the asteroid destroyed flag.
- ocupado  out  1  high in every state except IDLE.
- acertou  out  1  one-cycle pulse on asteroid destruction.
- db_estado  out  4  state code, for debug.

Behaviour:
- Async reset (reset=0): state IDLE, step counter 0, every output 0, db_estado=0. Reset mid-flight abandons the shot; memory contents are the datapath's concern.
- Outputs are Moore-decoded from state. Sole exception: conta_contador = (state==VARRE) & ~colisao.
- Direction decode, valid in every state: select_mux_coor = opcode[0]; select_soma_sub = (opcode==00 | opcode==11).
- Border for the current direction, called borda: 00→y_borda_min, 01→x_borda_max, 10→y_borda_max, 11→x_borda_min.
- State codes and transitions:
  - IDLE (0): go to CARREGA when disparar=1; otherwise stay.
  - CARREGA (1), 1 cycle: select_mux_pos=00, enable_reg_nave=1, enable_mem_load=1, new_load=1; step counter cleared. Then go to ZERA, so a shot spawned on an asteroid hits immediately.
  - ESPERA (2): wait for tick. On tick with borda=1 go to FIM (the border wins over the step). On tick with borda=0 go to MOVE.
  - MOVE (3), 1 cycle: select_mux_pos=01, enable_reg_nave=1. Then go to ZERA.
  - ZERA (4), 1 cycle: reset_cont=1. Then go to VARRE.
  - VARRE (5): colisao=1 goes to DESTROI; the counter holds, and colisao wins over rco_contador. rco_contador=1 with colisao=0 increments the step counter: if the count now equals MAX_PASSOS go to FIM, else go to ESPERA. Otherwise stay.
  - DESTROI (6), 1 cycle: enable_mem_aste=1, new_destruido=1, acertou=1. Then go to FIM.
  - FIM (7), 1 cycle: enable_mem_load=1, new_load=0, reset_reg_nave=1. Then go to IDLE.
- disparar while ocupado=1 is ignored, not queued.
- A tick arriving outside ESPERA is dropped.
- The step counter is 4-bit, saturates at MAX_PASSOS and never wraps.
- Sweep latency is 1 (ZERA) + 16 (VARRE) cycles for a full table.
- Latency from disparar to shot loaded: 1 cycle.

Decomposition:
- Package tiro_pkg holds:
  - state encoding (IDLE..FIM = 0..7);
  - opcode constants OP_CIMA, OP_DIR, OP_BAIXO, OP_ESQ;
  - select_mux_pos constants POS_NAVE, POS_SOMA.
- One sub-module, contador_passos: 4-bit clear/enable step counter with a terminal flag compared against MAX_PASSOS.

Test Plan:
- Reset low mid-VARRE → db_estado=0 and all outputs 0 immediately (asynchronous), without waiting for a clock edge.
- disparar=1, no collision, opcode=01, no border → CARREGA (enable_reg_nave=1, select_mux_pos=00, new_load=1), then ZERA, then 16 VARRE cycles with conta_contador=1, then ESPERA.
- In ESPERA with opcode=00: tick → MOVE with select_mux_coor=0, select_soma_sub=1, select_mux_pos=01.
- colisao=1 at sweep cycle 5, with rco_contador=1 forced in the same cycle → conta_contador=0, then DESTROI (enable_mem_aste=1, new_destruido=1, acertou=1 for one cycle), then FIM, then IDLE.
- opcode=11 with x_borda_min=1: tick → FIM (reset_reg_nave=1, enable_mem_load=1, new_load=0), MOVE never entered.
- MAX_PASSOS=3, no hits, ticks every 40 cycles → three sweeps, then FIM; disparar held high during flight causes no re-fire until IDLE.

Source files
------------

// File: rtl/tiro_pkg.sv
// -----------------------------------------------------------------------------
// tiro_pkg
// Shared definitions for the shot control unit (tiro_uc):
//   - estado_t   : FSM state encoding, IDLE..FIM = 0..7 (also the db_estado code)
//   - OP_*       : shot direction codes carried on opcode
//   - POS_*      : shot position register source selects
//   - saidas_t   : bundle of the state-decoded (Moore) control outputs
//   - decodifica : state -> control output bundle
//   - borda_dir  : picks the grid-edge flag that matters for a direction
// -----------------------------------------------------------------------------
package tiro_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CARREGA = 3'd1,
        ESPERA  = 3'd2,
        MOVE    = 3'd3,
        ZERA    = 3'd4,
        VARRE   = 3'd5,
        DESTROI = 3'd6,
        FIM     = 3'd7
    } estado_t;

    localparam logic [1:0] OP_CIMA  = 2'b00;  // y - 1
    localparam logic [1:0] OP_DIR   = 2'b01;  // x + 1
    localparam logic [1:0] OP_BAIXO = 2'b10;  // y + 1
    localparam logic [1:0] OP_ESQ   = 2'b11;  // x - 1

    localparam logic [1:0] POS_NAVE = 2'b00;  // ship position
    localparam logic [1:0] POS_SOMA = 2'b01;  // adder/subtractor result

    typedef struct packed {
        logic       reset_cont;
        logic [1:0] select_mux_pos;
        logic       enable_reg_nave;
        logic       reset_reg_nave;
        logic       enable_mem_aste;
        logic       enable_mem_load;
        logic       new_load;
        logic       new_destruido;
        logic       ocupado;
        logic       acertou;
    } saidas_t;

    // Control outputs that depend on the state alone.
    function automatic saidas_t decodifica(input estado_t e);
        saidas_t s;
        s         = '0;
        s.ocupado = (e != IDLE);
        case (e)
            CARREGA: begin
                s.select_mux_pos  = POS_NAVE;
                s.enable_reg_nave = 1'b1;
                s.enable_mem_load = 1'b1;
                s.new_load        = 1'b1;
            end
            MOVE: begin
                s.select_mux_pos  = POS_SOMA;
                s.enable_reg_nave = 1'b1;
            end
            ZERA: begin
                s.reset_cont = 1'b1;
            end
            DESTROI: begin
                s.enable_mem_aste = 1'b1;
                s.new_destruido   = 1'b1;
                s.acertou         = 1'b1;
            end
            FIM: begin
                // Clear the loaded flag (new_load stays 0) and the shot register.
                s.enable_mem_load = 1'b1;
                s.reset_reg_nave  = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

    // Edge flag in the direction of travel: one more step would leave the grid.
    function automatic logic borda_dir(input logic [1:0] op,
                                       input logic x_min, input logic x_max,
                                       input logic y_min, input logic y_max);
        logic b;
        case (op)
            OP_CIMA:  b = y_min;
            OP_DIR:   b = x_max;
            OP_BAIXO: b = y_max;
            default:  b = x_min;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tiro_uc_contador_passos.sv
// -----------------------------------------------------------------------------
// contador_passos
// 4-bit step counter for the shot range limit. Counts completed sweeps that
// ended without a hit; saturates at MAX_PASSOS and never wraps.
//   clock, reset : clock and asynchronous active-low reset
//   limpa        : synchronous clear (has priority over conta)
//   conta        : increment by one (ignored once saturated)
//   ultimo       : the next increment brings the count to MAX_PASSOS
// -----------------------------------------------------------------------------
module contador_passos #(
    parameter int MAX_PASSOS = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    output logic ultimo
);

    localparam logic [3:0] LIMITE = 4'(MAX_PASSOS);

    logic [3:0] passos;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            passos <= '0;
        end else if (limpa) begin
            passos <= '0;
        end else if (conta && (passos != LIMITE)) begin
            passos <= passos + 4'd1;
        end
    end

    // Flag is looked at in the same cycle as the increment, so compare against
    // the value the count is about to take.
    assign ultimo = (passos == (LIMITE - 4'd1));

endmodule

// File: rtl/tiro_uc.sv
// -----------------------------------------------------------------------------
// tiro_uc
// Control unit for the shot datapath. Loads the ship position on a fire
// request, steps the shot one cell per game tick, sweeps the asteroid table
// for a collision after every load/step, and unloads the shot on a hit, on
// reaching the grid edge, or after MAX_PASSOS sweeps without a hit.
//
// Inputs : clock, reset (async, active-low), disparar (fire, level),
//          tick (movement pulse), colisao / rco_contador (sweep status),
//          opcode (direction), x/y_borda_min/max (grid edge flags)
// Outputs: conta_contador, reset_cont (asteroid address counter),
//          select_mux_pos, select_mux_coor, select_soma_sub,
//          enable_reg_nave, reset_reg_nave (shot position register),
//          enable_mem_aste, new_destruido (asteroid destroyed flag write),
//          enable_mem_load, new_load (shot loaded flag write),
//          ocupado, acertou, db_estado (status/debug)
// -----------------------------------------------------------------------------
module tiro_uc
    import tiro_pkg::*;
#(
    parameter int MAX_PASSOS = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       disparar,
    input  logic       tick,
    input  logic       colisao,
    input  logic       rco_contador,
    input  logic [1:0] opcode,
    input  logic       x_borda_min,
    input  logic       x_borda_max,
    input  logic       y_borda_min,
    input  logic       y_borda_max,
    output logic       conta_contador,
    output logic       reset_cont,
    output logic [1:0] select_mux_pos,
    output logic       select_mux_coor,
    output logic       select_soma_sub,
    output logic       enable_reg_nave,
    output logic       reset_reg_nave,
    output logic       enable_mem_aste,
    output logic       enable_mem_load,
    output logic       new_load,
    output logic       new_destruido,
    output logic       ocupado,
    output logic       acertou,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t estado_prox;
    saidas_t saidas;
    logic    borda;
    logic    ultimo_passo;
    logic    fim_varredura;

    assign borda = borda_dir(opcode, x_borda_min, x_borda_max,
                             y_borda_min, y_borda_max);

    // A sweep ends without a hit only when the last address is reached and
    // there is no collision there; a collision always takes precedence.
    assign fim_varredura = (estado == VARRE) && rco_contador && !colisao;

    contador_passos #(
        .MAX_PASSOS (MAX_PASSOS)
    ) u_passos (
        .clock  (clock),
        .reset  (reset),
        .limpa  (estado == CARREGA),
        .conta  (fim_varredura),
        .ultimo (ultimo_passo)
    );

    // NOTE: the next-state value gets a default before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        estado_prox = estado;
        case (estado)
            IDLE:    if (disparar) estado_prox = CARREGA;
            // Sweep straight after loading so a shot spawned on an asteroid hits.
            CARREGA: estado_prox = ZERA;
            ESPERA:  if (tick) estado_prox = borda ? FIM : MOVE;
            MOVE:    estado_prox = ZERA;
            ZERA:    estado_prox = VARRE;
            VARRE: begin
                if (colisao)            estado_prox = DESTROI;
                else if (rco_contador)  estado_prox = ultimo_passo ? FIM : ESPERA;
            end
            DESTROI: estado_prox = FIM;
            FIM:     estado_prox = IDLE;
            default: estado_prox = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // together with the state and come out of flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
            saidas <= '0;
        end else begin
            estado <= estado_prox;
            saidas <= decodifica(estado_prox);
        end
    end

    assign reset_cont      = saidas.reset_cont;
    assign select_mux_pos  = saidas.select_mux_pos;
    assign enable_reg_nave = saidas.enable_reg_nave;
    assign reset_reg_nave  = saidas.reset_reg_nave;
    assign enable_mem_aste = saidas.enable_mem_aste;
    assign enable_mem_load = saidas.enable_mem_load;
    assign new_load        = saidas.new_load;
    assign new_destruido   = saidas.new_destruido;
    assign ocupado         = saidas.ocupado;
    assign acertou         = saidas.acertou;
    assign db_estado       = {1'b0, estado};

    // Stop advancing the address on a collision so DESTROI writes that entry.
    assign conta_contador  = (estado == VARRE) && !colisao;

    // Direction decode is independent of state.
    assign select_mux_coor = opcode[0];
    assign select_soma_sub = (opcode == OP_CIMA) || (opcode == OP_ESQ);

endmodule

// File: tb/tb_tiro_uc.sv
// -----------------------------------------------------------------------------
// tb_tiro_uc
// Directed bench for tiro_uc (MAX_PASSOS = 3). A small stand-in for the
// datapath supplies the asteroid address counter (16 entries) so rco_contador
// and colisao follow conta_contador/reset_cont. Stimulus pushes the expected
// state visits (state code, outputs on entry, dwell, conta_contador cycles)
// into a queue; a monitor pops an entry each time db_estado changes.
// -----------------------------------------------------------------------------
module tb_tiro_uc;

    localparam int MAX_PASSOS = 3;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CARREGA = 4'd1;
    localparam logic [3:0] S_ESPERA  = 4'd2;
    localparam logic [3:0] S_MOVE    = 4'd3;
    localparam logic [3:0] S_ZERA    = 4'd4;
    localparam logic [3:0] S_VARRE   = 4'd5;
    localparam logic [3:0] S_DESTROI = 4'd6;
    localparam logic [3:0] S_FIM     = 4'd7;

    // Output vector bit masks, MSB first:
    // {reset_cont, select_mux_pos[1:0], select_mux_coor, select_soma_sub,
    //  enable_reg_nave, reset_reg_nave, enable_mem_aste, enable_mem_load,
    //  new_load, new_destruido, ocupado, acertou}
    localparam logic [12:0] B_RESET_CONT = 13'h1000;
    localparam logic [12:0] B_POS_SOMA   = 13'h0400;
    localparam logic [12:0] B_COOR       = 13'h0200;
    localparam logic [12:0] B_SS         = 13'h0100;
    localparam logic [12:0] B_REG_EN     = 13'h0080;
    localparam logic [12:0] B_REG_RST    = 13'h0040;
    localparam logic [12:0] B_MEM_ASTE   = 13'h0020;
    localparam logic [12:0] B_MEM_LOAD   = 13'h0010;
    localparam logic [12:0] B_NEW_LOAD   = 13'h0008;
    localparam logic [12:0] B_NEW_DEST   = 13'h0004;
    localparam logic [12:0] B_OCUP       = 13'h0002;
    localparam logic [12:0] B_ACERTOU    = 13'h0001;

    // Direction bits (select_mux_coor, select_soma_sub) per opcode.
    localparam logic [12:0] D_CIMA  = B_SS;
    localparam logic [12:0] D_DIR   = B_COOR;
    localparam logic [12:0] D_BAIXO = 13'h0000;
    localparam logic [12:0] D_ESQ   = B_COOR | B_SS;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       disparar = 1'b0;
    logic       tick = 1'b0;
    logic       colisao;
    logic       rco_contador;
    logic [1:0] opcode = 2'b10;
    logic       x_borda_min = 1'b0;
    logic       x_borda_max = 1'b0;
    logic       y_borda_min = 1'b0;
    logic       y_borda_max = 1'b0;

    logic       conta_contador;
    logic       reset_cont;
    logic [1:0] select_mux_pos;
    logic       select_mux_coor;
    logic       select_soma_sub;
    logic       enable_reg_nave;
    logic       reset_reg_nave;
    logic       enable_mem_aste;
    logic       enable_mem_load;
    logic       new_load;
    logic       new_destruido;
    logic       ocupado;
    logic       acertou;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    tiro_uc #(
        .MAX_PASSOS (MAX_PASSOS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .disparar        (disparar),
        .tick            (tick),
        .colisao         (colisao),
        .rco_contador    (rco_contador),
        .opcode          (opcode),
        .x_borda_min     (x_borda_min),
        .x_borda_max     (x_borda_max),
        .y_borda_min     (y_borda_min),
        .y_borda_max     (y_borda_max),
        .conta_contador  (conta_contador),
        .reset_cont      (reset_cont),
        .select_mux_pos  (select_mux_pos),
        .select_mux_coor (select_mux_coor),
        .select_soma_sub (select_soma_sub),
        .enable_reg_nave (enable_reg_nave),
        .reset_reg_nave  (reset_reg_nave),
        .enable_mem_aste (enable_mem_aste),
        .enable_mem_load (enable_mem_load),
        .new_load        (new_load),
        .new_destruido   (new_destruido),
        .ocupado         (ocupado),
        .acertou         (acertou),
        .db_estado       (db_estado)
    );

    logic [12:0] dut_vec;
    assign dut_vec = {reset_cont, select_mux_pos, select_mux_coor, select_soma_sub,
                      enable_reg_nave, reset_reg_nave, enable_mem_aste,
                      enable_mem_load, new_load, new_destruido, ocupado, acertou};

    // Datapath stand-in: 16-entry asteroid address counter.
    logic [3:0] endereco;
    logic       hit_en    = 1'b0;
    logic [3:0] hit_addr  = 4'd0;
    logic       rco_forca = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset)              endereco <= 4'd0;
        else if (reset_cont)     endereco <= 4'd0;
        else if (conta_contador) endereco <= endereco + 4'd1;
    end

    assign colisao      = hit_en && (endereco == hit_addr);
    assign rco_contador = (endereco == 4'd15) || (rco_forca && colisao);

    // Scoreboard
    typedef struct {
        logic [3:0]  estado;
        logic [12:0] saidas;
        int          dwell;   // cycles in the state, 0 = don't care
        int          conta;   // cycles with conta_contador=1, -1 = don't care
    } esperado_t;

    esperado_t fila[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic check_vec(input string nome, input logic [12:0] act, input logic [12:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nome, act, exp, $time);
    endtask

    task automatic check_int(input string nome, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, act, exp, $time);
    endtask

    task automatic push(input logic [3:0] e, input logic [12:0] s, input int d, input int c);
        esperado_t r;
        r.estado = e;
        r.saidas = s;
        r.dwell  = d;
        r.conta  = c;
        fila.push_back(r);
    endtask

    task automatic push_disparo(input logic [12:0] dir);
        push(S_CARREGA, B_REG_EN | B_MEM_LOAD | B_NEW_LOAD | B_OCUP | dir, 1, -1);
        push(S_ZERA, B_RESET_CONT | B_OCUP | dir, 1, -1);
    endtask

    task automatic push_passo(input logic [12:0] dir);
        push(S_MOVE, B_POS_SOMA | B_REG_EN | B_OCUP | dir, 1, -1);
        push(S_ZERA, B_RESET_CONT | B_OCUP | dir, 1, -1);
    endtask

    task automatic push_fim(input logic [12:0] dir, input int dwell_idle);
        push(S_FIM, B_MEM_LOAD | B_REG_RST | B_OCUP | dir, 1, -1);
        push(S_IDLE, dir, dwell_idle, -1);
    endtask

    // Monitor: one scoreboard entry per state change.
    initial begin : monitor
        logic [3:0] prev;
        esperado_t  atual;
        bit         tem_atual;
        int         dwell;
        int         conta;
        prev      = S_IDLE;
        tem_atual = 1'b0;
        dwell     = 0;
        conta     = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev      = S_IDLE;
                tem_atual = 1'b0;
                dwell     = 0;
                conta     = 0;
            end else begin
                if (db_estado != prev) begin
                    if (tem_atual) begin
                        if (atual.dwell > 0) check_int($sformatf("dwell_estado%0d", prev), dwell, atual.dwell);
                        if (atual.conta >= 0) check_int($sformatf("conta_estado%0d", prev), conta, atual.conta);
                    end
                    if (fila.size() == 0) begin
                        n_total++;
                        $display("FAIL transicao_inesperada: got estado %0d from %0d, expected none (t=%0t)",
                                 db_estado, prev, $time);
                        tem_atual = 1'b0;
                    end else begin
                        atual = fila.pop_front();
                        check_int("estado", int'(db_estado), int'(atual.estado));
                        check_vec($sformatf("saidas_estado%0d", atual.estado), dut_vec, atual.saidas);
                        tem_atual = 1'b1;
                    end
                    prev  = db_estado;
                    dwell = 0;
                    conta = 0;
                end
                dwell++;
                if (conta_contador) conta++;
            end
        end
    end

    task automatic espera_fila(input int limite);
        int n = 0;
        while (fila.size() != 0 && n < limite) begin
            @(negedge clock);
            n++;
        end
        if (fila.size() != 0) begin
            n_total++;
            $display("FAIL timeout: %0d expected states still pending after %0d cycles", fila.size(), limite);
            fila.delete();
        end
    endtask

    task automatic pulso_tick();
        @(posedge clock); #2 tick = 1'b1;
        @(posedge clock); #2 tick = 1'b0;
    endtask

    initial begin : stimulus
        // Reset state (opcode=10 so the direction decode is also 0).
        repeat (2) @(posedge clock);
        #1;
        check_int("reset_estado", int'(db_estado), 0);
        check_vec("reset_saidas", dut_vec, 13'h0000);
        check_int("reset_conta_contador", int'(conta_contador), 0);
        #1 reset = 1'b1;

        // Fire right, full sweep with no hit, then wait for a tick.
        opcode = 2'b01;
        push_disparo(D_DIR);
        push(S_VARRE, B_OCUP | D_DIR, 16, 16);
        push(S_ESPERA, B_OCUP | D_DIR, 0, -1);
        @(posedge clock); #2 disparar = 1'b1;
        @(posedge clock); #2 disparar = 1'b0;
        espera_fila(60);

        // Up with every other edge flag set: step, sweep, back to waiting.
        opcode = 2'b00;
        x_borda_min = 1'b1; x_borda_max = 1'b1; y_borda_max = 1'b1;
        push_passo(D_CIMA);
        push(S_VARRE, B_OCUP | D_CIMA, 16, 16);
        push(S_ESPERA, B_OCUP | D_CIMA, 0, -1);
        pulso_tick();
        espera_fila(60);

        // Collision at sweep cycle 5 with rco forced there too (step count is
        // already 2, so rco winning would expire the shot instead).
        x_borda_min = 1'b0; x_borda_max = 1'b0; y_borda_max = 1'b0;
        hit_en = 1'b1; hit_addr = 4'd4; rco_forca = 1'b1;
        push_passo(D_CIMA);
        push(S_VARRE, B_OCUP | D_CIMA, 5, 4);
        push(S_DESTROI, B_MEM_ASTE | B_NEW_DEST | B_ACERTOU | B_OCUP | D_CIMA, 1, -1);
        push_fim(D_CIMA, 0);
        pulso_tick();
        espera_fila(60);
        hit_en = 1'b0; rco_forca = 1'b0;

        // New shot left (step count must restart), then left edge on tick.
        opcode = 2'b11;
        push_disparo(D_ESQ);
        push(S_VARRE, B_OCUP | D_ESQ, 16, 16);
        push(S_ESPERA, B_OCUP | D_ESQ, 0, -1);
        @(posedge clock); #2 disparar = 1'b1;
        @(posedge clock); #2 disparar = 1'b0;
        espera_fila(60);
        x_borda_min = 1'b1;
        push_fim(D_ESQ, 0);
        pulso_tick();
        espera_fila(20);
        x_borda_min = 1'b0;

        // Range limit: down, three sweeps, disparar held high throughout.
        // A stray tick during a sweep is dropped. After FIM the held request
        // fires again from IDLE.
        opcode = 2'b10;
        y_borda_min = 1'b1; x_borda_min = 1'b1; x_borda_max = 1'b1;
        push_disparo(D_BAIXO);
        push(S_VARRE, B_OCUP | D_BAIXO, 16, 16);
        push(S_ESPERA, B_OCUP | D_BAIXO, 0, -1);
        @(posedge clock); #2 disparar = 1'b1;
        espera_fila(60);
        push_passo(D_BAIXO);
        push(S_VARRE, B_OCUP | D_BAIXO, 16, 16);
        push(S_ESPERA, B_OCUP | D_BAIXO, 0, -1);
        pulso_tick();
        repeat (6) @(posedge clock);
        #2 tick = 1'b1;
        @(posedge clock); #2 tick = 1'b0;
        espera_fila(60);
        push_passo(D_BAIXO);
        push(S_VARRE, B_OCUP | D_BAIXO, 16, 16);
        push_fim(D_BAIXO, 1);
        push_disparo(D_BAIXO);
        push(S_VARRE, B_OCUP | D_BAIXO, 0, -1);
        pulso_tick();
        espera_fila(80);

        // Asynchronous reset in the middle of that sweep.
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        disparar = 1'b0;
        #1;
        check_int("reset_async_estado", int'(db_estado), 0);
        check_vec("reset_async_saidas", dut_vec, 13'h0000);
        check_int("reset_async_conta_contador", int'(conta_contador), 0);
        @(posedge clock); #2 reset = 1'b1;
        @(negedge clock);
        check_int("pos_reset_estado", int'(db_estado), 0);
        repeat (3) @(negedge clock);
        check_int("fila_vazia", fila.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
